// File: rtl/bcd_scan_display_pkg.sv
// Shared definitions for the multiplexed 3-digit BCD display: active-low segment
// codes and the digit-slot index type.
package bcd_scan_display_pkg;

   typedef enum logic [1:0] {
      ONES     = 2'd0,
      TENS     = 2'd1,
      HUNDREDS = 2'd2
   } digit_idx_e;

   typedef enum logic {
      StBlank,
      StOn
   } phase_e;

   // Active-low segment patterns, bit 0 = a ... bit 6 = g.
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   localparam logic [2:0] AN_OFF   = 3'b111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
   import bcd_scan_display_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_n_o
);

   always_comb begin
      seg_n_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_n_o = SEG_0;
         4'd1:    seg_n_o = SEG_1;
         4'd2:    seg_n_o = SEG_2;
         4'd3:    seg_n_o = SEG_3;
         4'd4:    seg_n_o = SEG_4;
         4'd5:    seg_n_o = SEG_5;
         4'd6:    seg_n_o = SEG_6;
         4'd7:    seg_n_o = SEG_7;
         4'd8:    seg_n_o = SEG_8;
         4'd9:    seg_n_o = SEG_9;
         default: seg_n_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 3-digit common-anode display driver with frame-synchronous
// digit commit, leading-zero blanking and inter-digit ghost blanking.
module bcd_scan_display
   import bcd_scan_display_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] hundreds_i,
   input  logic [3:0] tens_i,
   input  logic [3:0] ones_i,
   input  logic       load_i,
   input  logic       lz_en_i,
   output logic [6:0] seg_n_o,
   output logic [2:0] an_n_o,
   output logic       frame_o
);

   localparam int unsigned     CntW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0] LastCnt  = CntW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYCLES);
   localparam phase_e          PhaseRst = (BLANK_CYCLES != 0) ? StBlank : StOn;

   logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
   digit_idx_e      idx_q, idx_d;
   phase_e          phase_q, phase_d;
   logic [11:0]     staged_q, staged_d;
   logic [11:0]     shown_q, shown_d;
   logic            pending_q, pending_d;
   logic [2:0]      an_n_q, an_n_d;
   logic [6:0]      seg_n_q, seg_n_d;

   logic            slot_end;
   logic            commit;
   logic            digit_blank;
   logic [3:0]      digit_sel;
   logic [2:0]      an_sel_n;
   logic [6:0]      dec_seg_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt_q <= '0;
         idx_q      <= ONES;
         phase_q    <= PhaseRst;
         staged_q   <= '0;
         shown_q    <= '0;
         pending_q  <= 1'b0;
         an_n_q     <= AN_OFF;
         seg_n_q    <= SEG_OFF;
      end else begin
         slot_cnt_q <= slot_cnt_d;
         idx_q      <= idx_d;
         phase_q    <= phase_d;
         staged_q   <= staged_d;
         shown_q    <= shown_d;
         pending_q  <= pending_d;
         an_n_q     <= an_n_d;
         seg_n_q    <= seg_n_d;
      end
   end

   // Slot timing and phase next-state.
   always_comb begin
      slot_end   = (slot_cnt_q == LastCnt);
      slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
      idx_d      = idx_q;
      if (slot_end) begin
         unique case (idx_q)
            ONES:    idx_d = TENS;
            TENS:    idx_d = HUNDREDS;
            default: idx_d = ONES;
         endcase
      end
      phase_d = StOn;
      if ((BLANK_CYCLES != 0) && (slot_cnt_d < BlankCnt)) begin
         phase_d = StBlank;
      end
   end

   // Commit takes the pre-edge staged value, so a load on the commit cycle waits a frame.
   always_comb begin
      commit    = (idx_q == HUNDREDS) && slot_end && pending_q;
      staged_d  = load_i ? {hundreds_i, tens_i, ones_i} : staged_q;
      shown_d   = commit ? staged_q : shown_q;
      pending_d = load_i | (pending_q & ~commit);
   end

   always_comb begin
      digit_sel = shown_q[11:8];
      an_sel_n  = 3'b011;
      unique case (idx_q)
         ONES: begin
            digit_sel = shown_q[3:0];
            an_sel_n  = 3'b110;
         end
         TENS: begin
            digit_sel = shown_q[7:4];
            an_sel_n  = 3'b101;
         end
         default: begin
            digit_sel = shown_q[11:8];
            an_sel_n  = 3'b011;
         end
      endcase
      digit_blank = lz_en_i && (shown_q[11:8] == 4'd0) &&
                    ((idx_q == HUNDREDS) || ((idx_q == TENS) && (shown_q[7:4] == 4'd0)));
      an_n_d  = AN_OFF;
      seg_n_d = SEG_OFF;
      if ((phase_q == StOn) && !digit_blank) begin
         an_n_d  = an_sel_n;
         seg_n_d = dec_seg_n;
      end
   end

   bcd_to_seg7 u_dec (
      .bcd_i   (digit_sel),
      .seg_n_o (dec_seg_n)
   );

   assign seg_n_o = seg_n_q;
   assign an_n_o  = an_n_q;
   assign frame_o = commit;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized and directed check of bcd_scan_display against a cycle-position model.
module tb_bcd_scan_display;

   localparam int SD = 8;
   localparam int BL = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] hundreds_i, tens_i, ones_i;
   logic       load_i, lz_en_i;
   logic [6:0] seg_n_o;
   logic [2:0] an_n_o;
   logic       frame_o;

   int n_total = 0;
   int n_bad   = 0;

   // Model state: position since reset release, digit arrays indexed 0=ones..2=hundreds.
   int         m_pos;
   logic [3:0] m_stg[3];
   logic [3:0] m_shw[3];
   bit         m_pend;
   logic [2:0] m_an;
   logic [6:0] m_seg;
   logic [6:0] seg_hi[16];

   bcd_scan_display #(
      .SCAN_DIV     (SD),
      .BLANK_CYCLES (BL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hundreds_i (hundreds_i),
      .tens_i     (tens_i),
      .ones_i     (ones_i),
      .load_i     (load_i),
      .lz_en_i    (lz_en_i),
      .seg_n_o    (seg_n_o),
      .an_n_o     (an_n_o),
      .frame_o    (frame_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos  = 0;
      m_pend = 1'b0;
      m_an   = 3'b111;
      m_seg  = 7'h7F;
      for (int i = 0; i < 3; i++) begin
         m_stg[i] = 4'd0;
         m_shw[i] = 4'd0;
      end
   endtask

   // Outputs after an edge reflect the slot position and shown digits before it.
   task automatic model_step();
      int slot;
      int idx;
      bit lzb;
      slot = m_pos % SD;
      idx  = (m_pos / SD) % 3;
      lzb  = lz_en_i && (m_shw[2] == 4'd0) &&
             (idx == 2 || (idx == 1 && m_shw[1] == 4'd0));
      m_an  = 3'b111;
      m_seg = 7'h7F;
      if (slot >= BL && !lzb) begin
         m_an[idx] = 1'b0;
         m_seg     = ~seg_hi[m_shw[idx]];
      end
      if (idx == 2 && slot == SD - 1 && m_pend) begin
         m_shw  = m_stg;
         m_pend = 1'b0;
      end
      if (load_i) begin
         m_stg[0] = ones_i;
         m_stg[1] = tens_i;
         m_stg[2] = hundreds_i;
         m_pend   = 1'b1;
      end
      m_pos++;
   endtask

   function automatic bit exp_frame();
      return ((m_pos / SD) % 3 == 2) && (m_pos % SD == SD - 1) && m_pend;
   endfunction

   task automatic cyc(input bit ld, input logic [3:0] h, input logic [3:0] t,
                      input logic [3:0] o);
      load_i     = ld;
      hundreds_i = h;
      tens_i     = t;
      ones_i     = o;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("an_n", 12'(an_n_o), 12'(m_an));
      check("seg_n", 12'(seg_n_o), 12'(m_seg));
      check("frame", 12'(frame_o), 12'(exp_frame()));
      load_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, hundreds_i, tens_i, ones_i);
   endtask

   task automatic check_off(input string tag);
      check({tag, "_an"}, 12'(an_n_o), 12'h7);
      check({tag, "_seg"}, 12'(seg_n_o), 12'h7F);
      check({tag, "_frame"}, 12'(frame_o), 12'h0);
   endtask

   initial begin
      seg_hi[0]  = 7'h3F; seg_hi[1]  = 7'h06; seg_hi[2]  = 7'h5B; seg_hi[3]  = 7'h4F;
      seg_hi[4]  = 7'h66; seg_hi[5]  = 7'h6D; seg_hi[6]  = 7'h7D; seg_hi[7]  = 7'h07;
      seg_hi[8]  = 7'h7F; seg_hi[9]  = 7'h6F;
      for (int i = 10; i < 16; i++) seg_hi[i] = 7'h40;

      rst_n      = 1'b0;
      load_i     = 1'b0;
      lz_en_i    = 1'b0;
      hundreds_i = 4'd0;
      tens_i     = 4'd0;
      ones_i     = 4'd0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_off("rst");
      end
      rst_n = 1'b1;

      // Blank display "000" with no load and no frame pulses.
      idle(48);

      // First load commits at the first hundreds slot end.
      idle(2);
      cyc(1'b1, 4'd1, 4'd2, 4'd7);
      idle(60);

      // Leading-zero blanking.
      lz_en_i = 1'b1;
      cyc(1'b1, 4'd0, 4'd0, 4'd5);
      idle(50);
      cyc(1'b1, 4'd0, 4'd4, 4'd0);
      idle(50);

      // Latest load wins, then a load exactly on the commit cycle.
      lz_en_i = 1'b0;
      for (int g = 0; g < 30 && (m_pos % (3 * SD)) != 3 * SD - 4; g++) idle(1);
      cyc(1'b1, 4'd9, 4'd9, 4'd9);
      cyc(1'b1, 4'd2, 4'd5, 4'd5);
      for (int g = 0; g < 30 && (m_pos % (3 * SD)) != 3 * SD - 1; g++) idle(1);
      check("commit_align", 12'(m_pos % (3 * SD)), 12'(3 * SD - 1));
      cyc(1'b1, 4'd1, 4'd1, 4'd1);
      idle(60);

      // Invalid hundreds digit shows a dash and is not blanked.
      lz_en_i = 1'b1;
      cyc(1'b1, 4'hC, 4'd0, 4'd1);
      idle(40);

      // Asynchronous reset mid-ON with a pending load.
      cyc(1'b1, 4'd3, 4'd3, 4'd3);
      for (int g = 0; g < 10 && (m_pos % SD) != 4; g++) idle(1);
      #2 rst_n = 1'b0;
      #1 check_off("arst");
      model_reset();
      @(negedge clk);
      check_off("arst_hold");
      rst_n = 1'b1;
      idle(60);

      // Randomized loads and blanking mode changes.
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 49) == 0) lz_en_i = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 14) == 0) begin
            cyc(1'b1,
                ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)));
         end else begin
            idle(1);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the binary-to-BCD converter's hundreds/tens/ones digits.
- Captures a digit triple on a load strobe and commits it at frame boundaries so the display never tears mid-frame.
- Drives a 3-digit, common-anode, time-multiplexed 7-segment display with leading-zero blanking and an inter-digit ghost-blanking interval.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz); legal when >= BLANK_CYCLES+2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; legal range 0..SCAN_DIV-2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- hundreds  in  4  BCD hundreds digit
- tens  in  4  BCD tens digit
- ones  in  4  BCD ones digit
- load  in  1  one-cycle strobe; samples the three digit inputs
- lz_en  in  1  1 = leading-zero blanking enabled
- seg_n  out  7  active-low segments; seg_n[0]=a ... seg_n[6]=g
- an_n  out  3  active-low anodes; an_n[0]=ones, an_n[1]=tens, an_n[2]=hundreds
- frame  out  1  one-cycle pulse on the cycle a commit occurs

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- While rst_n=0: slot_cnt=0, idx=0, phase=BLANK, staged and shown digits=0, pending=0, an_n=3'b111, seg_n=7'h7F, frame=0.
- Counters and state:
  - slot_cnt counts 0..SCAN_DIV-1, then wraps to 0 and advances idx 0 -> 1 -> 2 -> 0.
  - phase FSM: BLANK while slot_cnt < BLANK_CYCLES, ON otherwise.
  - When BLANK_CYCLES=0, BLANK never occurs.
- Capture: when load=1, staged <= {hundreds, tens, ones} and pending <= 1. With repeated loads before a commit, the latest load wins.
- Commit:
  - Occurs on the cycle where idx=2, slot_cnt=SCAN_DIV-1 and pending=1.
  - Action: shown <= staged, pending <= 0, frame=1 for that cycle.
  - No commit and no frame pulse when pending=0.
- Load on a commit cycle:
  - The commit uses staged as it was before that cycle.
  - The load writes the new staged value and leaves pending=1, so it commits at the next frame boundary.
- Outputs are registered: an_n and seg_n reflect the current (idx, phase, shown) one cycle later.
- During BLANK: an_n=3'b111 and seg_n=7'h7F.
- During ON: an_n has only bit idx low, and seg_n carries the decoded shown digit for idx.
- Decode (active-high segments gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Values 10..15 show a dash, g only (seg_n=7'h3F).
  - seg_n is the bitwise inverse of these codes.
- Leading-zero blanking, when lz_en=1:
  - Hundreds digit blanked if shown hundreds=0.
  - Tens digit blanked if shown hundreds=0 and shown tens=0.
  - Ones digit is never blanked.
  - A blanked digit keeps the scan timing: the slot occurs with an_n=3'b111 for the whole slot.
  - An invalid hundreds digit (>9) is not zero and is never blanked.
- lz_en is sampled every cycle; no capture is needed.
- Reset mid-operation: immediate return to reset values. Staged and pending data are lost.

Decomposition:
- Shared package: the segment-code constants SEG_0..SEG_9 and SEG_DASH, SEG_OFF (7'h7F active-low), and the digit-index typedef (2-bit, values ONES/TENS/HUNDREDS).
- One natural combinational sub-module, bcd_to_seg7: 4-bit BCD in, 7-bit active-low segments out, including the dash for 10..15. It is reusable by any future direct-drive display.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2 unless noted):
- Reset, then no load for 48 cycles -> seg_n=7'h7F and an_n=3'b111 during reset. After reset, lz_en=0 shows "000": seg_n=7'h40 during ON phases, with anodes 110/101/011 in rotation. No frame pulse.
- load with 1/2/7 at cycle 3 -> frame pulses exactly at the first idx=2 slot end. Next frame shows an_n=110 with seg_n=~07, an_n=101 with ~5B, an_n=011 with ~06. Each digit is ON for 6 cycles and off for 2.
- lz_en=1 and load 0/0/5 -> hundreds and tens slots keep an_n=3'b111 for the full 8 cycles; the ones slot shows ~6D. Load 0/4/0 -> hundreds blank, tens ~66, ones ~3F.
- Two loads (9/9/9, then 2/5/5) before the boundary -> only 2/5/5 is shown. Load 1/1/1 on the commit cycle -> 2/5/5 commits now, 1/1/1 commits one frame later, and frame pulses twice.
- Load hundreds=4'hC with lz_en=1 -> hundreds slot shows the dash (seg_n=7'h3F) and is not blanked.
- Assert rst_n low for one cycle mid-ON while pending=1 -> outputs go to 7'h7F/3'b111 asynchronously. After release, shown=0/0/0 and no frame pulse occurs without a new load.
